// File: rtl/sprite_index_gen.sv
// Per-pixel scene compositor: renders a 3-bit palette index for each VGA pixel
// from frame-latched game state, with a fixed two-cycle latency.
module sprite_index_gen #(
    parameter int         ANIM_FRAMES = 30,
    parameter logic [9:0] PLAYER_Y    = 10'd440
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pixel_valid,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    input  logic        frame_start,
    input  logic [9:0]  player_x,
    input  logic [9:0]  form_x,
    input  logic [9:0]  form_y,
    input  logic [54:0] alive,
    input  logic        pb_active,
    input  logic [9:0]  pb_x,
    input  logic [9:0]  pb_y,
    input  logic        eb_active,
    input  logic [9:0]  eb_x,
    input  logic [9:0]  eb_y,
    output logic [2:0]  index,
    output logic        index_valid
);

    localparam logic [7:0] ANIM_LAST = 8'(ANIM_FRAMES - 1);

    logic [9:0]  sh_player_x, sh_form_x, sh_form_y;
    logic [54:0] sh_alive;
    logic        sh_pb_active, sh_eb_active;
    logic [9:0]  sh_pb_x, sh_pb_y, sh_eb_x, sh_eb_y;
    logic [7:0]  anim_cnt;
    logic        anim_sel;

    // Object state is captured once per frame so a frame never shows mixed state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_player_x  <= '0;
            sh_form_x    <= '0;
            sh_form_y    <= '0;
            sh_alive     <= '0;
            sh_pb_active <= 1'b0;
            sh_pb_x      <= '0;
            sh_pb_y      <= '0;
            sh_eb_active <= 1'b0;
            sh_eb_x      <= '0;
            sh_eb_y      <= '0;
        end else if (frame_start) begin
            sh_player_x  <= player_x;
            sh_form_x    <= form_x;
            sh_form_y    <= form_y;
            sh_alive     <= alive;
            sh_pb_active <= pb_active;
            sh_pb_x      <= pb_x;
            sh_pb_y      <= pb_y;
            sh_eb_active <= eb_active;
            sh_eb_x      <= eb_x;
            sh_eb_y      <= eb_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anim_cnt <= '0;
            anim_sel <= 1'b0;
        end else if (frame_start) begin
            if (anim_cnt == ANIM_LAST) begin
                anim_cnt <= '0;
                anim_sel <= ~anim_sel;
            end else begin
                anim_cnt <= anim_cnt + 8'd1;
            end
        end
    end

    function automatic logic in_range(input logic [10:0] d, input logic [10:0] lim);
        return !d[10] && (d < lim);
    endfunction

    function automatic logic [15:0] alien_bitmap(input logic frame, input logic [2:0] row);
        case (row)
            3'd0:    return 16'h0660;
            3'd1:    return 16'h0FF0;
            3'd2:    return 16'h1FF8;
            3'd3:    return 16'h399C;
            3'd4:    return 16'h3FFC;
            3'd5:    return 16'h0990;
            3'd6:    return frame ? 16'h2424 : 16'h1008;
            default: return frame ? 16'h4002 : 16'h0810;
        endcase
    endfunction

    function automatic logic [15:0] player_bitmap(input logic [2:0] row);
        case (row)
            3'd0:    return 16'h0180;
            3'd1:    return 16'h03C0;
            3'd2:    return 16'h03C0;
            3'd3:    return 16'h3FFC;
            3'd4:    return 16'h7FFE;
            default: return 16'hFFFF;
        endcase
    endfunction

    // Differences are 11 bits wide so a pixel left of or above an object shows up as negative.
    logic [10:0] a_dx, a_dy, p_dx, p_dy, pb_dx, pb_dy, eb_dx, eb_dy;
    assign a_dx  = {1'b0, draw_x} - {1'b0, sh_form_x};
    assign a_dy  = {1'b0, draw_y} - {1'b0, sh_form_y};
    assign p_dx  = {1'b0, draw_x} - {1'b0, sh_player_x};
    assign p_dy  = {1'b0, draw_y} - {1'b0, PLAYER_Y};
    assign pb_dx = {1'b0, draw_x} - {1'b0, sh_pb_x};
    assign pb_dy = {1'b0, draw_y} - {1'b0, sh_pb_y};
    assign eb_dx = {1'b0, draw_x} - {1'b0, sh_eb_x};
    assign eb_dy = {1'b0, draw_y} - {1'b0, sh_eb_y};

    logic [3:0] a_col;
    logic [2:0] a_row;
    logic [5:0] alive_idx;
    logic       a_cell, a_alive, p_box, pb_box, eb_box;

    assign a_col     = a_dx[8:5];
    assign a_row     = a_dy[6:4];
    assign alive_idx = ({3'b000, a_row} * 6'd11) + {2'b00, a_col};
    assign a_cell    = in_range(a_dx, 11'd352) && in_range(a_dy, 11'd80) && !a_dx[4] && !a_dy[3];
    assign a_alive   = (alive_idx < 6'd55) ? sh_alive[alive_idx] : 1'b0;
    assign p_box     = in_range(p_dx, 11'd16) && in_range(p_dy, 11'd8);
    assign pb_box    = sh_pb_active && in_range(pb_dx, 11'd2) && in_range(pb_dy, 11'd6);
    assign eb_box    = sh_eb_active && in_range(eb_dx, 11'd2) && in_range(eb_dy, 11'd6);

    logic       s1_valid, s1_alien, s1_alien_top, s1_frame, s1_player, s1_pb, s1_eb;
    logic [3:0] s1_ax, s1_px;
    logic [2:0] s1_ay, s1_py;

    // Everything that depends on shadow state is resolved here, so a frame_start
    // landing between the two stages cannot leak new state into an older pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_alien     <= 1'b0;
            s1_alien_top <= 1'b0;
            s1_frame     <= 1'b0;
            s1_player    <= 1'b0;
            s1_pb        <= 1'b0;
            s1_eb        <= 1'b0;
            s1_ax        <= '0;
            s1_ay        <= '0;
            s1_px        <= '0;
            s1_py        <= '0;
        end else begin
            s1_valid     <= pixel_valid;
            s1_alien     <= a_cell && a_alive;
            s1_alien_top <= (a_row < 3'd2);
            s1_frame     <= anim_sel;
            s1_player    <= p_box;
            s1_pb        <= pb_box;
            s1_eb        <= eb_box;
            s1_ax        <= a_dx[3:0];
            s1_ay        <= a_dy[2:0];
            s1_px        <= p_dx[3:0];
            s1_py        <= p_dy[2:0];
        end
    end

    logic [15:0] alien_row_bits, player_row_bits;
    logic [3:0]  alien_bit, player_bit;
    logic        alien_pix, player_pix;
    logic [2:0]  next_index;

    assign alien_row_bits  = alien_bitmap(s1_frame, s1_ay);
    assign player_row_bits = player_bitmap(s1_py);
    assign alien_bit       = 4'd15 - s1_ax;
    assign player_bit      = 4'd15 - s1_px;
    assign alien_pix       = alien_row_bits[alien_bit];
    assign player_pix      = player_row_bits[player_bit];

    always_comb begin
        next_index = 3'd0;
        if (!s1_valid)
            next_index = 3'd6;
        else if (s1_eb)
            next_index = 3'd4;
        else if (s1_pb)
            next_index = 3'd1;
        else if (s1_player && player_pix)
            next_index = 3'd2;
        else if (s1_alien && alien_pix)
            next_index = s1_alien_top ? 3'd3 : 3'd5;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index       <= 3'd6;
            index_valid <= 1'b0;
        end else begin
            index       <= next_index;
            index_valid <= s1_valid;
        end
    end

endmodule

// File: tb/tb_sprite_index_gen.sv
// Self-checking bench for sprite_index_gen: directed vectors from hand-derived
// constants plus a randomized stream checked against a behavioural pixel model.
module tb_sprite_index_gen;

    localparam int ANIM    = 2;
    localparam int PLAYERY = 440;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        pixel_valid = 1'b0;
    logic [9:0]  draw_x = '0, draw_y = '0;
    logic        frame_start = 1'b0;
    logic [9:0]  player_x = '0, form_x = '0, form_y = '0;
    logic [54:0] alive = '0;
    logic        pb_active = 1'b0, eb_active = 1'b0;
    logic [9:0]  pb_x = '0, pb_y = '0, eb_x = '0, eb_y = '0;
    logic [2:0]  index;
    logic        index_valid;

    sprite_index_gen #(.ANIM_FRAMES(ANIM), .PLAYER_Y(10'(PLAYERY))) dut (
        .clk(clk), .rst_n(rst_n), .pixel_valid(pixel_valid),
        .draw_x(draw_x), .draw_y(draw_y), .frame_start(frame_start),
        .player_x(player_x), .form_x(form_x), .form_y(form_y), .alive(alive),
        .pb_active(pb_active), .pb_x(pb_x), .pb_y(pb_y),
        .eb_active(eb_active), .eb_x(eb_x), .eb_y(eb_y),
        .index(index), .index_valid(index_valid)
    );

    always #5 clk = ~clk;

    typedef struct { string name; logic [2:0] idx; logic vld; } exp_t;
    typedef struct { string name; int x; int y; logic [2:0] exp; } vec_t;

    exp_t exp_q[$];
    vec_t vecs[16];
    int   compared = 0;
    int   mismatched = 0;

    int alien_bm[2][8] = '{'{'h0660, 'h0FF0, 'h1FF8, 'h399C, 'h3FFC, 'h0990, 'h1008, 'h0810},
                           '{'h0660, 'h0FF0, 'h1FF8, 'h399C, 'h3FFC, 'h0990, 'h2424, 'h4002}};
    int player_bm[8] = '{'h0180, 'h03C0, 'h03C0, 'h3FFC, 'h7FFE, 'hFFFF, 'hFFFF, 'hFFFF};

    // Frame-latched view of the scene as the model sees it.
    int          m_player_x, m_form_x, m_form_y, m_pb_x, m_pb_y, m_eb_x, m_eb_y;
    logic [54:0] m_alive;
    bit          m_pb_a, m_eb_a;
    int          m_cnt;
    int          m_sel;

    function automatic void model_reset();
        m_player_x = 0; m_form_x = 0; m_form_y = 0; m_alive = '0;
        m_pb_a = 0; m_pb_x = 0; m_pb_y = 0; m_eb_a = 0; m_eb_x = 0; m_eb_y = 0;
        m_cnt = 0; m_sel = 0;
    endfunction

    function automatic void model_frame();
        m_player_x = int'(player_x); m_form_x = int'(form_x); m_form_y = int'(form_y);
        m_alive = alive;
        m_pb_a = pb_active; m_pb_x = int'(pb_x); m_pb_y = int'(pb_y);
        m_eb_a = eb_active; m_eb_x = int'(eb_x); m_eb_y = int'(eb_y);
        if (m_cnt == ANIM - 1) begin
            m_cnt = 0;
            m_sel = 1 - m_sel;
        end else begin
            m_cnt = m_cnt + 1;
        end
    endfunction

    function automatic bit in_box(input int dx, input int dy, input int w, input int h);
        return dx >= 0 && dx < w && dy >= 0 && dy < h;
    endfunction

    // Lower-priority objects are painted first so higher ones overwrite them.
    function automatic void ref_pixel(input bit valid, input int x, input int y,
                                      output logic [2:0] idx, output logic vld);
        int dx, dy, row, col, ro, co;
        idx = 3'd6;
        vld = 1'b0;
        if (valid) begin
            vld = 1'b1;
            idx = 3'd0;
            dx = x - m_form_x;
            dy = y - m_form_y;
            if (in_box(dx, dy, 352, 80)) begin
                col = dx / 32; co = dx % 32;
                row = dy / 16; ro = dy % 16;
                if (co < 16 && ro < 8 && m_alive[row * 11 + col] == 1'b1 &&
                    ((alien_bm[m_sel][ro] >> (15 - co)) & 1) == 1)
                    idx = (row < 2) ? 3'd3 : 3'd5;
            end
            dx = x - m_player_x;
            dy = y - PLAYERY;
            if (in_box(dx, dy, 16, 8) && ((player_bm[dy] >> (15 - dx)) & 1) == 1)
                idx = 3'd2;
            if (m_pb_a && in_box(x - m_pb_x, y - m_pb_y, 2, 6))
                idx = 3'd1;
            if (m_eb_a && in_box(x - m_eb_x, y - m_eb_y, 2, 6))
                idx = 3'd4;
        end
    endfunction

    task automatic checkOutput();
        exp_t e;
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        compared++;
        if (index !== e.idx || index_valid !== e.vld) begin
            mismatched++;
            $display("[TB] FAIL %s: got index=%0d valid=%0b, expected index=%0d valid=%0b",
                     e.name, index, index_valid, e.idx, e.vld);
        end
    endtask

    task automatic applyStimulus(input bit valid, input int x, input int y, input bit fs,
                                 input bit use_const, input logic [2:0] cexp, input string name);
        exp_t e;
        pixel_valid = valid;
        draw_x      = 10'(x);
        draw_y      = 10'(y);
        frame_start = fs;
        if (use_const) begin
            e.idx = cexp;
            e.vld = 1'b1;
        end else begin
            ref_pixel(valid, x, y, e.idx, e.vld);
        end
        e.name = name;
        exp_q.push_back(e);
        @(posedge clk);
        if (fs) model_frame();
        #1;
        checkOutput();
        frame_start = 1'b0;
    endtask

    task automatic checkResetOutput(input string name);
        compared++;
        if (index !== 3'd6 || index_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL %s: got index=%0d valid=%0b, expected index=6 valid=0",
                     name, index, index_valid);
        end
    endtask

    // Reset is asserted away from the clock edge, so the outputs must clear with no edge.
    task automatic doReset(input string name);
        exp_t e;
        rst_n = 1'b0;
        #1;
        checkResetOutput(name);
        model_reset();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        e.name = {name, "_flush"};
        e.idx  = 3'd6;
        e.vld  = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic frame();
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b0, 3'd0, "frame_start");
    endtask

    task automatic runVec(input int i);
        applyStimulus(1'b1, vecs[i].x, vecs[i].y, 1'b0, 1'b1, vecs[i].exp, vecs[i].name);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 3'd0, "idle");
    endtask

    initial begin
        vecs[0]  = '{"alien_hit",        106,  50, 3'd3};
        vecs[1]  = '{"alien_blank_bit",  100,  50, 3'd0};
        vecs[2]  = '{"alien_gap_col",    116,  50, 3'd0};
        vecs[3]  = '{"f0_row6_off1",     101,  56, 3'd0};
        vecs[4]  = '{"f0_row6_off2",     102,  56, 3'd0};
        vecs[5]  = '{"player_top",       307, 440, 3'd2};
        vecs[6]  = '{"player_corner",    300, 440, 3'd0};
        vecs[7]  = '{"player_bottom",    300, 447, 3'd2};
        vecs[8]  = '{"f1_row6_off1",     101,  56, 3'd0};
        vecs[9]  = '{"f1_row6_off2",     102,  56, 3'd3};
        vecs[10] = '{"dead_alien",       202,  82, 3'd0};
        vecs[11] = '{"live_alien_row2",  202,  82, 3'd5};
        vecs[12] = '{"eb_over_all",      106,  50, 3'd4};
        vecs[13] = '{"pb_over_alien",    106,  50, 3'd1};
        vecs[14] = '{"live_inputs_held", 106,  50, 3'd3};
        vecs[15] = '{"fs_next_new",      106,  50, 3'd0};

        player_x = 10'd300; form_x = 10'd100; form_y = 10'd50; alive = '1;
        pb_x = 10'd106; pb_y = 10'd50; eb_x = 10'd106; eb_y = 10'd50;

        #3;
        doReset("reset_init");
        idle(2);

        frame();
        for (int i = 0; i < 8; i++) runVec(i);
        frame();
        for (int i = 8; i < 10; i++) runVec(i);

        alive[2*11+3] = 1'b0;
        frame();
        runVec(10);
        alive[2*11+3] = 1'b1;
        frame();
        runVec(11);

        pb_active = 1'b1; eb_active = 1'b1;
        frame();
        runVec(12);
        eb_active = 1'b0;
        frame();
        runVec(13);
        pb_active = 1'b0;
        frame();

        form_x = 10'd200;
        runVec(14);
        applyStimulus(1'b1, 106, 50, 1'b1, 1'b1, 3'd3, "fs_same_cycle_old");
        runVec(15);
        idle(2);

        // Randomized streaming with live state churn; frame_start sometimes lands on valid pixels.
        for (int i = 0; i < 640; i++) begin
            int x, y;
            bit fs;
            if (i % 16 == 5) begin
                player_x  = 10'($urandom_range(0, 620));
                form_x    = 10'($urandom_range(0, 300));
                form_y    = 10'($urandom_range(0, 400));
                alive     = 55'({$urandom(), $urandom()});
                pb_active = 1'($urandom_range(0, 1));
                eb_active = 1'($urandom_range(0, 1));
                pb_x = 10'($urandom_range(0, 630)); pb_y = 10'($urandom_range(0, 470));
                eb_x = 10'($urandom_range(0, 630)); eb_y = 10'($urandom_range(0, 470));
            end
            fs = (i % 64 == 13);
            case ($urandom_range(0, 7))
                0: begin x = m_eb_x + $urandom_range(0, 3); y = m_eb_y + $urandom_range(0, 7); end
                1: begin x = m_pb_x + $urandom_range(0, 3); y = m_pb_y + $urandom_range(0, 7); end
                2: begin x = m_player_x + $urandom_range(0, 17); y = PLAYERY - 1 + $urandom_range(0, 9); end
                3, 4: begin x = m_form_x + $urandom_range(0, 355); y = m_form_y + $urandom_range(0, 82); end
                default: begin x = $urandom_range(0, 639); y = $urandom_range(0, 479); end
            endcase
            if (x > 639) x = 639;
            if (y > 479) y = 479;
            applyStimulus(1'($urandom_range(0, 1)), x, y, fs, 1'b0, 3'd0, "random_stream");
            if (i == 320) begin
                applyStimulus(1'b1, 106, 50, 1'b0, 1'b0, 3'd0, "pre_reset_pixel");
                applyStimulus(1'b1, 107, 50, 1'b0, 1'b0, 3'd0, "pre_reset_pixel");
                #2;
                doReset("reset_midstream");
                frame();
            end
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sprite_index_gen.md
# sprite_index_gen

Per-pixel scene compositor for the Space Invaders video path. It takes the VGA controller's draw coordinates and the game state (player, alien formation, bullets), and renders the 3-bit palette index for each pixel with a fixed 2-cycle latency. The palette lookup immediately downstream converts that index to 4-bit RGB. Object state is latched once per frame so each frame is drawn without tearing, and an internal counter alternates the alien animation frames.

## Interface
Parameters:
- ANIM_FRAMES, 30: number of frame_start pulses between alien animation toggles (legal range 1–255).
- PLAYER_Y, 440: top row of the player sprite.

Ports:
- clk  in  1  pixel clock. One clock for the whole block. Reset is asynchronous and active-low.
- rst_n  in  1  asynchronous, active-low reset.
- pixel_valid  in  1  draw_x/draw_y is an active-area pixel this cycle.
- draw_x  in  10  pixel column, 0–639.
- draw_y  in  10  pixel row, 0–479.
- frame_start  in  1  one-cycle pulse, issued only during vertical blanking.
- player_x  in  10  left column of the player.
- form_x  in  10  left column of the alien formation.
- form_y  in  10  top row of the alien formation.
- alive  in  55  alien alive mask, bit index r*11+c (r = row 0–4, c = column 0–10).
- pb_active  in  1  player bullet exists.
- pb_x, pb_y  in  10 each  player bullet top-left position.
- eb_active  in  1  enemy bullet exists.
- eb_x, eb_y  in  10 each  enemy bullet top-left position.
- index  out  3  palette index.
- index_valid  out  1  index corresponds to an active pixel.

## Operation
- Shadow registers hold all object inputs (player_x … eb_y). They load only on a cycle where frame_start=1. Rendering always uses the shadow values, never the live inputs.
- Animation:
  - anim_cnt (8 bit) increments on each frame_start.
  - When it equals ANIM_FRAMES-1 it wraps to 0 and anim_sel toggles.
- Geometry. All comparisons use 11-bit differences. A negative difference is a miss, with no wrap-around.
  - Alien cell:
    - dx = draw_x-form_x and dy = draw_y-form_y.
    - c = dx[8:5] and r = dy[7:4].
    - A hit requires 0≤dx<352, 0≤dy<80, dx[4]=0, dy[3]=0, alive[r*11+c]=1, and an alien bitmap bit of 1 at (dx[3:0], dy[2:0]).
  - Player: a 16×8 box at (player_x, PLAYER_Y), masked by the player bitmap.
  - Bullets: solid 2×6 boxes, and only when the matching _active flag is set.
- Bitmaps. Each is 16-bit rows listed top to bottom; bit 15 is the leftmost pixel.
  - Alien frame 0: 0660 0FF0 1FF8 399C 3FFC 0990 1008 0810.
  - Alien frame 1: same as frame 0 except rows 6–7 are 2424 4002.
  - Player: 0180 03C0 03C0 3FFC 7FFE FFFF FFFF FFFF.
- Index priority, highest first:
  - enemy bullet → 4
  - player bullet → 1
  - player → 2
  - alien rows 0–1 → 3
  - alien rows 2–4 → 5
  - otherwise → 0
- pixel_valid=0 → index 6 and index_valid 0.

## Timing
- Pipeline stage 1 registers the differences, the in-box flags, c, r, the bitmap offsets and pixel_valid. Stage 2 registers index and index_valid.
- Latency is exactly 2 cycles: inputs at cycle N produce output at cycle N+2. Throughput is one pixel per cycle with no stalls.
- frame_start at cycle N:
  - Shadow registers and anim state update at the N→N+1 edge.
  - A pixel presented at cycle N uses the old shadow values.
  - frame_start coinciding with pixel_valid=1 is legal; the pixel is rendered with the old state.
- Reset (asynchronous assert, released on the clock edge) clears:
  - index to 6 and index_valid to 0;
  - both pipeline stages, flushing any in-flight pixels to invalid;
  - all shadow registers to 0, including alive=0, so no aliens are drawn until the first frame_start;
  - anim_cnt to 0 and anim_sel to 0.
- Reset mid-line: in-flight pixels are dropped, with no partial output.

## Test plan
- Reset, then one frame_start with form=(100,50), alive=all 1s, and a pixel at (106,50) → index 3 with index_valid=1 exactly 2 cycles later. Pixel (100,50) → index 0 (bitmap bit 0). Pixel (116,50), which falls in the gap column → index 0.
- Clear alive bit 2*11+3, then pixel (100+96+6, 50+32) → index 0. With the bit set → index 5.
- Overlap: set eb and pb both at (106,50), on top of an alien → index 4. Clear eb_active → index 1.
- ANIM_FRAMES=2, pixel (101,56), which is row 6, offset 1:
  - frame 0 → bitmap bit 14 of 1008 is 0 → index 0;
  - after 2 frame_starts, frame 1 (2424 → bit 14 is 0) → index 0;
  - pixel (102,56) after 2 frame_starts → bit 13 of 2424 is 1 → index 3.
- Change form_x live without frame_start → output unchanged. Then pulse frame_start together with a valid pixel → that pixel uses the old values and the next pixel uses the new ones.
- Streaming 640 pixels with pixel_valid toggling → index_valid mirrors pixel_valid delayed by 2. Assert rst_n low mid-stream → index=6 and index_valid=0 immediately, and no stale outputs after release.
